// File: rtl/frame_buffer_rw.sv
// Parametrised single-port frame store: full-frame write, read and clear.
// Stream sides use valid/ready handshakes; commands start only from IDLE.
module frame_buffer_rw #(
    parameter int                DATA_W    = 8,
    parameter int                WIDTH     = 450,
    parameter int                HEIGHT    = 450,
    parameter int                ADDR_W    = 18,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ptr
);

    localparam int                DEPTH = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CLEAR
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          rst_sync_q;
    logic                rst_i_n;
    logic [ADDR_W-1:0]   ptr_q;
    logic                rd_last_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                done_q;
    logic                busy_q;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic                fetch;
    logic                cmd_done;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Reset asserts asynchronously and releases on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_i_n = rst_sync_q[1];

    // State register
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort always returns to IDLE and beats a new start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    unique case (op)
                        2'b00:   state_d = S_READ;
                        2'b01:   state_d = S_WRITE;
                        2'b10:   state_d = S_CLEAR;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid && ptr_q == LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rd_last_q && out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ptr_q == LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state strobes: memory write, read fetch and normal completion
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = in_data;
        fetch     = 1'b0;
        in_ready  = 1'b0;
        unique case (state_q)
            S_WRITE: begin
                in_ready = 1'b1;
                mem_we   = in_valid && !abort;
            end
            S_READ: begin
                fetch = !abort && !rd_last_q && (!out_valid_q || out_ready);
            end
            S_CLEAR: begin
                mem_we    = !abort;
                mem_wdata = CLEAR_VAL;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        cmd_done = (state_q != S_IDLE) && (state_d == S_IDLE) && !abort;
    end

    // Pointer, read-pipeline valid and status flags
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            ptr_q       <= '0;
            rd_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q      <= cmd_done;
            busy_q      <= (state_d != S_IDLE);
            out_valid_q <= (state_d != S_IDLE) &&
                           (fetch || (out_valid_q && !out_ready));
            if (state_d == S_IDLE) begin
                ptr_q     <= '0;
                rd_last_q <= 1'b0;
            end else if (mem_we || fetch) begin
                if (ptr_q == LAST) begin
                    rd_last_q <= fetch;
                end else begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Synchronous read port, one-cycle latency
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            out_data_q <= '0;
        end else if (fetch) begin
            out_data_q <= mem[ptr_q];
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= mem_wdata;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ptr       = ptr_q;

endmodule

// File: doc/frame_buffer_rw.md
Name: frame_buffer_rw

Overview:
Parametrised single-port frame store for pixel streams of any width and any frame size. It replaces the fixed 8-bit, 450x450 RWM store. It supports three commands: write a full frame, read a full frame, and clear the memory to a fill value. Both stream sides use valid/ready handshakes with stall tolerance. Commands are issued by the controller, input pixels come from the grayscaling stage, and output pixels go to the downstream filter stage.

Parameters:
DATA_W, 8, pixel width in bits
WIDTH, 450, pixels per line
HEIGHT, 450, lines per frame
DEPTH, WIDTH*HEIGHT, words stored (derived; not overridden)
ADDR_W, 18, pointer width; must satisfy 2^ADDR_W >= DEPTH
CLEAR_VAL, 0, fill value written by the clear command (DATA_W bits)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
op  in  2  command: 00 read, 01 write, 10 clear, 11 reserved (ignored)
abort  in  1  terminate the current command
in_valid  in  1  in_data holds a pixel
in_data  in  DATA_W  write pixel
in_ready  out  1  block accepts in_data this cycle
out_valid  out  1  out_data holds a pixel
out_data  out  DATA_W  read pixel
out_ready  in  1  consumer accepts out_data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal command completion
ptr  out  ADDR_W  current word pointer

Behaviour:
- Reset (async assert, sync release): state IDLE, ptr=0, out_valid=0, out_data=0, done=0, busy=0, in_ready=0. Memory contents are not reset.
- States: IDLE, WRITE, READ, CLEAR.
- IDLE:
  - start=1 with op=00/01/10 moves to READ/WRITE/CLEAR on the next edge, with ptr=0.
  - op=11, or start while not IDLE, is ignored.
  - start and abort in the same cycle: abort wins and the command is ignored.
- WRITE:
  - in_ready=1 throughout WRITE.
  - Each cycle with in_valid & in_ready writes mem[ptr]<=in_data and increments ptr.
  - in_valid gaps hold ptr; there is no WAIT state.
  - The write at ptr==DEPTH-1 returns to IDLE: ptr=0, done=1 for the next cycle only.
- READ:
  - Memory read is synchronous, one-cycle latency.
  - A fetch is issued when ptr<DEPTH and (out_valid==0 or out_ready==1). A fetch loads out_data<=mem[ptr], sets out_valid=1 and increments ptr.
  - With out_ready held high, one word is delivered per cycle with no bubbles. The first out_valid appears 1 cycle after entering READ.
  - While out_valid & !out_ready, out_data and ptr hold; no drop and no duplicate.
  - out_valid clears after the handshake of word DEPTH-1, then the block returns to IDLE with the done pulse.
  - in_ready=0 in READ.
- CLEAR:
  - Writes mem[ptr]<=CLEAR_VAL each cycle with no handshake, so it takes exactly DEPTH cycles.
  - Returns to IDLE with the done pulse after writing ptr==DEPTH-1.
- Abort (any non-IDLE state): the next edge gives IDLE, ptr=0, out_valid=0, no done pulse. Words already written stay written.
- ptr wraps only by returning to IDLE; it never exceeds DEPTH-1.
- done and busy are registered outputs. busy falls in the same cycle that done rises.
- Asserting rst_n low mid-command clears out_valid/busy immediately (asynchronously); nothing further is written.

Test Plan:
- WIDTH=4, HEIGHT=4, DEPTH=16: write command, pixels 0x10..0x1F with in_valid low every third cycle -> 16 writes. done pulses once, exactly 1 cycle after the handshake of 0x1F. busy then low.
- Read the same frame with out_ready toggling 1,0,0,1… -> out_data sequence 0x10..0x1F with no drops or duplicates. Data holds while stalled. done pulses once after the last handshake.
- Read with out_ready=1 constant -> 16 consecutive out_valid cycles starting 1 cycle after entering READ. done in the cycle after the last word.
- CLEAR_VAL=0xAA: clear command -> busy for exactly 16 cycles, then done. A subsequent read returns 16 words of 0xAA.
- Write 0x00..0x0F, then a second write of 0x50..0x54 with abort asserted after the 5th handshake -> IDLE next cycle, no done. A read returns 0x50..0x54 followed by 0x05..0x0F.
- start with op=01 while READ is busy, start with op=11 in IDLE, and start+abort together -> all ignored. Asserting rst_n low mid-read -> out_valid=0 and busy=0 immediately, ptr=0.
